// File: rtl/pipe_pkg.sv
// Shared widths, func encodings and stage bundles
// for the three-stage load pipeline.
package pipe_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    FN_WORD = 2'b00,
    FN_LBU  = 2'b01,
    FN_HBU  = 2'b10,
    FN_LB   = 2'b11
  } func_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    func_e             func;
    logic [DATA_W-1:0] data;
  } l12_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } l23_t;

endpackage

// File: rtl/pipe_load_fmt.sv
// Result formatter: word, zero-extended low/high
// byte, or sign-extended low byte. Ports: func, din, dout.
module pipe_load_fmt
  import pipe_pkg::*;
(
  input  func_e             func,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    dout = '0;
    unique case (func)
      FN_WORD: dout = din;
      FN_LBU:  dout = {8'h00, din[7:0]};
      FN_HBU:  dout = {8'h00, din[15:8]};
      FN_LB:   dout = {{8{din[7]}}, din[7:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/pipe_load.sv
// Three-register load pipeline: request/memory read,
// format, writeback; z/load_cnt track accepted beats.
// Ports: clk_1, rst, req_*, mem_*, wb_*, z, load_cnt.
module pipe_load
  import pipe_pkg::*;
(
  input  logic              clk_1,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_rd,
  input  logic [1:0]        req_func,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] z,
  output logic [CNT_W-1:0]  load_cnt
);

  logic              advance;
  logic              fire;
  logic              pend;
  l12_t              l12;
  l23_t              l23;
  logic [DATA_W-1:0] fmt_in;
  logic [DATA_W-1:0] fmt_out;

  assign advance   = !wb_valid || wb_ready;
  assign req_ready = advance;
  // no memory strobe may escape while reset is held
  assign fire      = req_valid && advance && !rst;
  assign mem_ren   = fire;
  assign mem_raddr = fire ? req_addr : '0;

  // read data lands one cycle after fire; if L12 is
  // stalled then, it was parked in l12.data
  assign fmt_in = pend ? mem_rdata : l12.data;

  pipe_load_fmt u_fmt (
    .func (l12.func),
    .din  (fmt_in),
    .dout (fmt_out)
  );

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      l12  <= '0;
    end else begin
      pend <= fire;
      if (pend)
        l12.data <= mem_rdata;
      if (advance) begin
        l12.valid <= fire;
        l12.rd    <= req_rd;
        l12.func  <= func_e'(req_func);
      end
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      l23 <= '0;
    end else if (advance) begin
      l23.valid <= l12.valid;
      l23.rd    <= l12.rd;
      l23.data  <= fmt_out;
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (advance) begin
      wb_valid <= l23.valid;
      wb_rd    <= l23.rd;
      wb_data  <= l23.data;
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      z        <= '0;
      load_cnt <= '0;
    end else if (wb_valid && wb_ready) begin
      z        <= wb_data;
      load_cnt <= load_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_load.sv
// Randomized bench for pipe_load with a queue-based
// reference model of memory, formatting and counters.
module tb_pipe_load;
  import pipe_pkg::*;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_rd;
  logic [1:0]  req_func;
  logic        mem_ren;
  logic [7:0]  mem_raddr;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic [15:0] z;
  logic [7:0]  load_cnt;

  always #5 clk_1 = ~clk_1;

  pipe_load dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_rd    (req_rd),
    .req_func  (req_func),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .z         (z),
    .load_cnt  (load_cnt)
  );

  logic [15:0] mem [256];

  // data valid only the cycle after a strobe; junk otherwise
  always @(posedge clk_1)
    mem_rdata <= mem_ren ? mem[mem_raddr] : 16'($urandom);

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          nfire = 0;
  int          nwb = 0;
  logic [15:0] ez = '0;
  logic [7:0]  ecnt = '0;
  bit          strict = 0;
  bit          exp_stall = 0;
  bit          hold_v = 0;
  logic [3:0]  hold_rd;
  logic [15:0] hold_data;
  logic [15:0] last_data;
  logic [3:0]  last_rd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_fmt(
    input logic [15:0] w, input logic [1:0] fn);
    int b;
    case (fn)
      2'd0: return w;
      2'd1: return w % 256;
      2'd2: return w / 256;
      default: begin
        b = int'(w % 256);
        if (b >= 128) b = b - 256;
        return 16'(b);
      end
    endcase
  endfunction

  task automatic step(input logic v, input logic [7:0] a,
                      input logic [3:0] rd,
                      input logic [1:0] fn,
                      input logic wr);
    logic f;
    exp_t e;
    req_valid = v;
    req_addr  = a;
    req_rd    = rd;
    req_func  = fn;
    wb_ready  = wr;
    @(negedge clk_1);
    cyc++;
    f = req_valid && req_ready;
    chk("mem_ren", 32'(mem_ren), 32'(f));
    chk("mem_raddr", 32'(mem_raddr), f ? 32'(a) : 32'd0);
    chk("req_ready", 32'(req_ready),
        32'(!wb_valid || wb_ready));
    if (strict) chk("ready_hi", 32'(req_ready), 32'd1);
    if (exp_stall) chk("stall_rdy", 32'(req_ready), 32'd0);
    if (hold_v) begin
      chk("hold_valid", 32'(wb_valid), 32'd1);
      chk("hold_rd", 32'(wb_rd), 32'(hold_rd));
      chk("hold_data", 32'(wb_data), 32'(hold_data));
    end
    chk("z", 32'(z), 32'(ez));
    chk("load_cnt", 32'(load_cnt), 32'(ecnt));
    if (wb_valid && wb_ready) begin
      if (q.size() == 0) begin
        chk("spurious_wb", 32'(wb_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", 32'(wb_data), 32'(e.data));
        if (strict) chk("latency", 32'(cyc - e.cyc), 32'd3);
        ez = e.data;
        ecnt = ecnt + 8'd1;
        last_data = wb_data;
        last_rd = wb_rd;
        nwb++;
      end
    end
    hold_v    = wb_valid && !wb_ready;
    hold_rd   = wb_rd;
    hold_data = wb_data;
    if (f) begin
      q.push_back('{rd, ref_fmt(mem[a], fn), cyc});
      nfire++;
    end
    @(posedge clk_1);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++)
      step(1'b0, 8'h0, 4'h0, 2'd0, 1'b1);
    chk("drain", 32'(q.size()), 32'd0);
    step(1'b0, 8'h0, 4'h0, 2'd0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    wb_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_1);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_ren", 32'(mem_ren), 32'd0);
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_cnt", 32'(load_cnt), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      @(posedge clk_1);
    end
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    q.delete();
    ez = '0;
    ecnt = '0;
    nwb = 0;
    nfire = 0;
    hold_v = 0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_rd = '0;
    req_func = '0;
    wb_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hA5F0;

    do_reset();

    // single word load, exact latency
    strict = 1;
    step(1'b1, 8'h10, 4'd3, 2'd0, 1'b1);
    drain();
    chk("w_data", 32'(last_data), 32'hA5F0);
    chk("w_rd", 32'(last_rd), 32'd3);
    chk("w_z", 32'(z), 32'hA5F0);
    chk("w_cnt", 32'(load_cnt), 32'd1);

    step(1'b1, 8'h10, 4'd4, 2'd1, 1'b1);
    drain();
    chk("f01", 32'(last_data), 32'h00F0);
    step(1'b1, 8'h10, 4'd5, 2'd2, 1'b1);
    drain();
    chk("f10", 32'(last_data), 32'h00A5);
    step(1'b1, 8'h10, 4'd6, 2'd3, 1'b1);
    drain();
    chk("f11", 32'(last_data), 32'hFFF0);

    // four back-to-back loads, unstalled
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'($urandom), 4'(i + 8),
           2'($urandom), 1'b1);
    drain();
    chk("b2b_cnt", 32'(load_cnt), 32'd8);
    strict = 0;

    // stall right after a fire, 5 cycles
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'($urandom), 4'($urandom),
           2'($urandom), 1'b1);
    exp_stall = 1;
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'($urandom), 4'($urandom),
           2'($urandom), 1'b0);
    exp_stall = 0;
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'($urandom), 4'($urandom),
           2'($urandom), 1'b1);
    drain();
    chk("stall_cnt", 32'(load_cnt), 32'd15);

    // reset with three loads in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'($urandom), 4'($urandom),
           2'($urandom), 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h0, 4'h0, 2'd0, 1'b1);
      chk("post_rst_wb", 32'(wb_valid), 32'd0);
    end

    // random stream with stalls, exactly 256 loads
    for (int i = 0; i < 5000 && nfire < 256; i++)
      step(1'($urandom % 4 != 0), 8'($urandom),
           4'($urandom), 2'($urandom),
           1'($urandom % 4 != 0));
    chk("nfire", 32'(nfire), 32'd256);
    drain();
    chk("nwb", 32'(nwb), 32'd256);
    chk("wrap", 32'(load_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
